// File: rtl/pipeline_stall_ctrl_pkg.sv
// rtl/pipeline_stall_ctrl_pkg.sv - shared state, hazard-class and control-bundle definitions
package pipeline_stall_ctrl_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_RUN        = 2'b01,
        ST_BR_RESOLVE = 2'b10,
        ST_MEM_WAIT   = 2'b11
    } state_t;

    localparam logic [1:0] HZ_NONE     = 2'b00;
    localparam logic [1:0] HZ_LOAD_USE = 2'b01;
    localparam logic [1:0] HZ_BRANCH   = 2'b10;
    localparam logic [1:0] HZ_JUMP     = 2'b11;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic exmem_hold;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '{default: 1'b0};

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// rtl/pipeline_stall_ctrl_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Holds at all-ones rather than wrapping so long stalls never read as short ones.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - hazard/stall/flush sequencing for a 5-stage pipeline
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             HD_i,
    input  logic [1:0]       type_i,
    input  logic             branch_taken_i,
    input  logic             mem_stall_i,
    output logic             PC_write_o,
    output logic             IFID_write_o,
    output logic             IFID_flush_o,
    output logic             IDEX_bubble_o,
    output logic             EXMEM_hold_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    state_t state;
    state_t next_state;
    state_t saved_state;
    state_t next_saved;
    state_t eff_state;
    ctrl_t  ctrl;
    logic   stall_inc;
    logic   flush_inc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            saved_state <= ST_RUN;
        end else begin
            state       <= next_state;
            saved_state <= next_saved;
        end
    end

    // MEM_WAIT behaves as the interrupted state once memory releases, so decode from eff_state.
    always_comb begin
        ctrl       = CTRL_NONE;
        next_state = state;
        next_saved = saved_state;
        eff_state  = (state == ST_MEM_WAIT) ? saved_state : state;

        if (state == ST_IDLE) begin
            if (start_i) begin
                next_state = ST_RUN;
            end
        end else if (mem_stall_i) begin
            ctrl.exmem_hold = 1'b1;
            next_saved      = eff_state;
            next_state      = ST_MEM_WAIT;
        end else begin
            case (eff_state)
                ST_BR_RESOLVE: begin
                    ctrl.pc_write   = 1'b1;
                    ctrl.ifid_flush = branch_taken_i;
                    ctrl.ifid_write = !branch_taken_i;
                    next_state      = ST_RUN;
                end
                default: begin
                    next_state = ST_RUN;
                    if (!HD_i) begin
                        ctrl.pc_write   = 1'b1;
                        ctrl.ifid_write = 1'b1;
                    end else begin
                        case (type_i)
                            HZ_BRANCH: begin
                                ctrl.ifid_flush = 1'b1;
                                next_state      = ST_BR_RESOLVE;
                            end
                            HZ_JUMP: begin
                                ctrl.pc_write   = 1'b1;
                                ctrl.ifid_flush = 1'b1;
                            end
                            default: begin
                                ctrl.idex_bubble = 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign PC_write_o    = ctrl.pc_write;
    assign IFID_write_o  = ctrl.ifid_write;
    assign IFID_flush_o  = ctrl.ifid_flush;
    assign IDEX_bubble_o = ctrl.idex_bubble;
    assign EXMEM_hold_o  = ctrl.exmem_hold;

    assign stall_inc = (state != ST_IDLE) && !ctrl.pc_write;
    assign flush_inc = ctrl.ifid_flush;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk_i),
        .clr   (rst_i),
        .en    (stall_inc),
        .count (stall_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk_i),
        .clr   (rst_i),
        .en    (flush_inc),
        .count (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - scoreboard bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        HD_i = 1'b0;
    logic [1:0]  type_i = 2'b00;
    logic        branch_taken_i = 1'b0;
    logic        mem_stall_i = 1'b0;
    logic        PC_write_o;
    logic        IFID_write_o;
    logic        IFID_flush_o;
    logic        IDEX_bubble_o;
    logic        EXMEM_hold_o;
    logic [15:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;

    int checks = 0;
    int failures = 0;

    // Expected {PC_write, IFID_write, IFID_flush, IDEX_bubble, EXMEM_hold}
    localparam logic [4:0] O_IDLE = 5'b00000;
    localparam logic [4:0] O_RUN  = 5'b11000;
    localparam logic [4:0] O_LU   = 5'b00010;
    localparam logic [4:0] O_BR   = 5'b00100;
    localparam logic [4:0] O_JMP  = 5'b10100;
    localparam logic [4:0] O_BRT  = 5'b10100;
    localparam logic [4:0] O_BRN  = 5'b11000;
    localparam logic [4:0] O_HOLD = 5'b00001;

    logic [4:0] exp_q[$];

    pipeline_stall_ctrl dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .HD_i           (HD_i),
        .type_i         (type_i),
        .branch_taken_i (branch_taken_i),
        .mem_stall_i    (mem_stall_i),
        .PC_write_o     (PC_write_o),
        .IFID_write_o   (IFID_write_o),
        .IFID_flush_o   (IFID_flush_o),
        .IDEX_bubble_o  (IDEX_bubble_o),
        .EXMEM_hold_o   (EXMEM_hold_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Scoreboard drain: one expected control vector per driven cycle, checked mid-cycle.
    always @(negedge clk_i) begin
        logic [4:0] act;
        logic [4:0] exp;
        act = {PC_write_o, IFID_write_o, IFID_flush_o, IDEX_bubble_o, EXMEM_hold_o};
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL ctrl_outputs t=%0t actual=%b expected=%b", $time, act, exp);
            end
        end
        if (!rst_i) begin
            checks++;
            if (IFID_write_o && IFID_flush_o) begin
                failures++;
                $display("FAIL write_flush_exclusive t=%0t actual=11 expected=not both", $time);
            end
        end
    end

    task automatic drive(input logic st, input logic hd, input logic [1:0] ty,
                         input logic bt, input logic ms, input logic [4:0] exp);
        start_i        = st;
        HD_i           = hd;
        type_i         = ty;
        branch_taken_i = bt;
        mem_stall_i    = ms;
        exp_q.push_back(exp);
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i          = 1'b0;
        start_i        = 1'b0;
        HD_i           = 1'b0;
        type_i         = 2'b00;
        branch_taken_i = 1'b0;
        mem_stall_i    = 1'b0;
    endtask

    task automatic test_reset();
        start_i = 1'b1; HD_i = 1'b1; type_i = 2'b10; mem_stall_i = 1'b1;
        do_reset();
        checks++;
        if (stall_cnt_o !== 16'h0 || flush_cnt_o !== 16'h0) begin
            failures++;
            $display("FAIL reset_counters actual=%h/%h expected=0000/0000", stall_cnt_o, flush_cnt_o);
        end
        drive(0, 1, 2'b01, 1, 1, O_IDLE);
        drive(0, 0, 2'b00, 0, 0, O_IDLE);
    endtask

    task automatic test_run();
        do_reset();
        drive(1, 0, 2'b00, 0, 0, O_IDLE);
        for (int i = 0; i < 4; i++) drive(1, 0, 2'b00, 0, 0, O_RUN);
        checks++;
        if (stall_cnt_o !== 16'd0 || flush_cnt_o !== 16'd0) begin
            failures++;
            $display("FAIL run_counters actual=%0d/%0d expected=0/0", stall_cnt_o, flush_cnt_o);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 0, 2'b00, 0, 0, O_IDLE);
        drive(0, 1, 2'b01, 0, 0, O_LU);
        drive(0, 0, 2'b00, 0, 0, O_RUN);
        checks++;
        if (stall_cnt_o !== 16'd1) begin
            failures++;
            $display("FAIL load_use_stall_cnt actual=%0d expected=1", stall_cnt_o);
        end
        drive(0, 1, 2'b00, 1, 0, O_LU);
        drive(0, 0, 2'b00, 0, 0, O_RUN);
        checks++;
        if (stall_cnt_o !== 16'd2 || flush_cnt_o !== 16'd0) begin
            failures++;
            $display("FAIL unclassified_cnt actual=%0d/%0d expected=2/0", stall_cnt_o, flush_cnt_o);
        end
    endtask

    task automatic test_branch(input logic taken);
        do_reset();
        drive(1, 0, 2'b00, 0, 0, O_IDLE);
        drive(0, 1, 2'b10, 0, 0, O_BR);
        drive(0, 1, 2'b01, taken, 0, taken ? O_BRT : O_BRN);
        drive(0, 0, 2'b00, 0, 0, O_RUN);
        checks++;
        if (flush_cnt_o !== (taken ? 16'd2 : 16'd1) || stall_cnt_o !== 16'd1) begin
            failures++;
            $display("FAIL branch_cnt taken=%0d actual=%0d/%0d expected=%0d/1",
                     taken, flush_cnt_o, stall_cnt_o, taken ? 2 : 1);
        end
    endtask

    task automatic test_jump();
        do_reset();
        drive(1, 0, 2'b00, 0, 0, O_IDLE);
        drive(0, 1, 2'b11, 0, 0, O_JMP);
        drive(0, 0, 2'b00, 1, 0, O_RUN);
        checks++;
        if (flush_cnt_o !== 16'd1 || stall_cnt_o !== 16'd0) begin
            failures++;
            $display("FAIL jump_cnt actual=%0d/%0d expected=1/0", flush_cnt_o, stall_cnt_o);
        end
    endtask

    task automatic test_mem_stall_branch();
        do_reset();
        drive(1, 0, 2'b00, 0, 0, O_IDLE);
        drive(0, 1, 2'b10, 0, 0, O_BR);
        for (int i = 0; i < 3; i++) drive(0, 1, 2'b10, 1, 1, O_HOLD);
        drive(0, 0, 2'b00, 1, 0, O_BRT);
        drive(0, 0, 2'b00, 0, 0, O_RUN);
        checks++;
        if (stall_cnt_o !== 16'd4 || flush_cnt_o !== 16'd2) begin
            failures++;
            $display("FAIL mem_stall_branch_cnt actual=%0d/%0d expected=4/2", stall_cnt_o, flush_cnt_o);
        end
    endtask

    task automatic test_mem_stall_run();
        do_reset();
        drive(0, 0, 2'b00, 0, 1, O_IDLE);
        drive(1, 0, 2'b00, 0, 0, O_IDLE);
        drive(0, 1, 2'b11, 0, 1, O_HOLD);
        drive(0, 1, 2'b01, 0, 0, O_LU);
        drive(0, 0, 2'b00, 0, 0, O_RUN);
        checks++;
        if (stall_cnt_o !== 16'd2 || flush_cnt_o !== 16'd0) begin
            failures++;
            $display("FAIL mem_stall_run_cnt actual=%0d/%0d expected=2/0", stall_cnt_o, flush_cnt_o);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        drive(1, 0, 2'b00, 0, 0, O_IDLE);
        for (int i = 0; i < 65536; i++) drive(0, 1, 2'b01, 0, 0, O_LU);
        checks++;
        if (stall_cnt_o !== 16'hFFFF) begin
            failures++;
            $display("FAIL stall_saturate actual=%h expected=ffff", stall_cnt_o);
        end
        drive(0, 1, 2'b01, 0, 0, O_LU);
        drive(0, 0, 2'b00, 0, 1, O_HOLD);
        checks++;
        if (stall_cnt_o !== 16'hFFFF) begin
            failures++;
            $display("FAIL stall_hold_sat actual=%h expected=ffff", stall_cnt_o);
        end
        mem_stall_i = 1'b1;
        do_reset();
        checks++;
        if (stall_cnt_o !== 16'h0 || flush_cnt_o !== 16'h0) begin
            failures++;
            $display("FAIL reset_mem_wait_cnt actual=%h/%h expected=0000/0000", stall_cnt_o, flush_cnt_o);
        end
        drive(0, 0, 2'b00, 0, 1, O_IDLE);
        drive(0, 0, 2'b00, 0, 0, O_IDLE);
    endtask

    initial begin
        test_reset();
        test_run();
        test_load_use();
        test_branch(1'b1);
        test_branch(1'b0);
        test_jump();
        test_mem_stall_branch();
        test_mem_stall_run();
        test_saturation();
        @(negedge clk_i);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
